// File: rtl/cbd_sampler_arbiter.sv
// Round-robin arbiter that shares one CBD sampler job port between N_REQ requesters.
// Optional watchdog on the sampler wait is enabled by defining CBD_ARB_TIMEOUT_EN.
module cbd_sampler_arbiter #(
  parameter int N_REQ          = 2,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [N_REQ-1:0]     req_i,
  input  logic [N_REQ*256-1:0] req_seed_i,
  input  logic [N_REQ*8-1:0]   req_N_i,
  input  logic [N_REQ-1:0]     req_eta_i,
  output logic [N_REQ-1:0]     gnt_o,
  output logic [N_REQ-1:0]     rsp_valid_o,
  input  logic [N_REQ-1:0]     rsp_ready_i,
  output logic [2047:0]        rsp_poly_o,
  output logic                 smp_run_o,
  output logic [255:0]         smp_seed_o,
  output logic [7:0]           smp_N_o,
  output logic                 smp_eta_o,
  input  logic                 smp_done_i,
  input  logic [2047:0]        smp_poly_i,
  output logic                 busy_o,
  output logic                 err_o
);

  localparam int IDX_W = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("cbd_sampler_arbiter: unsupported N_REQ or TIMEOUT_CYCLES");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_owner;
  logic [IDX_W-1:0] r_last;
  logic [255:0]     r_seed;
  logic [7:0]       r_N;
  logic             r_eta;
  logic [2047:0]    r_poly;

  logic             w_found;
  logic [IDX_W-1:0] w_idx;
  logic [255:0]     w_seed_sel;
  logic [7:0]       w_N_sel;
  logic             w_eta_sel;

  // Scan from the highest offset down so the nearest requester after r_last wins.
  always_comb begin
    logic [IDX_W-1:0] cand;
    w_found = 1'b0;
    w_idx   = '0;
    cand    = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = IDX_W'((int'(r_last) + k) % N_REQ);
      if (req_i[cand]) begin
        w_found = 1'b1;
        w_idx   = cand;
      end
    end
  end

  always_comb begin
    w_seed_sel = '0;
    w_N_sel    = '0;
    w_eta_sel  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_idx == IDX_W'(i)) begin
        w_seed_sel = req_seed_i[256*i +: 256];
        w_N_sel    = req_N_i[8*i +: 8];
        w_eta_sel  = req_eta_i[i];
      end
    end
  end

  // Grant is a same-cycle decode; masked during reset so nothing is offered then.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_port
    assign gnt_o[gi]       = rst_n_i && (r_state == S_IDLE) && w_found && (w_idx == IDX_W'(gi));
    assign rsp_valid_o[gi] = (r_state == S_RESP) && (r_owner == IDX_W'(gi));
  end

  assign smp_run_o  = (r_state == S_ISSUE);
  assign busy_o     = (r_state != S_IDLE);
  assign smp_seed_o = r_seed;
  assign smp_N_o    = r_N;
  assign smp_eta_o  = r_eta;
  assign rsp_poly_o = r_poly;

`ifdef CBD_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_err;
  assign err_o = r_err;
`else
  assign err_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
      r_owner <= '0;
      r_last  <= IDX_W'(N_REQ - 1);
      r_seed  <= '0;
      r_N     <= '0;
      r_eta   <= 1'b0;
      r_poly  <= '0;
`ifdef CBD_ARB_TIMEOUT_EN
      r_wait_cnt <= '0;
      r_err      <= 1'b0;
`endif
    end else begin
`ifdef CBD_ARB_TIMEOUT_EN
      r_err <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_seed  <= w_seed_sel;
            r_N     <= w_N_sel;
            r_eta   <= w_eta_sel;
            r_owner <= w_idx;
            r_last  <= w_idx;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
`ifdef CBD_ARB_TIMEOUT_EN
          r_wait_cnt <= '0;
`endif
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // A done arriving together with the timeout still captures normally.
          if (smp_done_i) begin
            r_poly  <= smp_poly_i;
            r_state <= S_RESP;
          end
`ifdef CBD_ARB_TIMEOUT_EN
          else if (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
`endif
        end
        S_RESP: begin
          if (rsp_ready_i[r_owner]) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cbd_sampler_arbiter.sv
// Directed self-checking bench for cbd_sampler_arbiter with two requesters.
module tb_cbd_sampler_arbiter;

  localparam int N = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req;
  logic [N*256-1:0] req_seed;
  logic [N*8-1:0]   req_N;
  logic [N-1:0]     req_eta;
  logic [N-1:0]     gnt;
  logic [N-1:0]     rsp_valid;
  logic [N-1:0]     rsp_ready;
  logic [2047:0]    rsp_poly;
  logic             run;
  logic [255:0]     smp_seed;
  logic [7:0]       smp_N;
  logic             smp_eta;
  logic             done;
  logic [2047:0]    smp_poly;
  logic             busy;
  logic             err;

  int checks = 0;
  int errors = 0;

  logic [2047:0] p1, p2, p3, p4, p5, p6, p7, p8;
  logic [255:0]  seed0_a, seed0_b, seed1_b;

  always #5 clk = ~clk;

  cbd_sampler_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_i(req), .req_seed_i(req_seed), .req_N_i(req_N), .req_eta_i(req_eta),
    .gnt_o(gnt), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_poly_o(rsp_poly),
    .smp_run_o(run), .smp_seed_o(smp_seed), .smp_N_o(smp_N), .smp_eta_o(smp_eta),
    .smp_done_i(done), .smp_poly_i(smp_poly), .busy_o(busy), .err_o(err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_poly(input string tag, input logic [2047:0] exp);
    checks++;
    assert (rsp_poly === exp) else begin
      errors++;
      $error("FAIL %s observed(lo64)=%0h expected(lo64)=%0h", tag, rsp_poly[63:0], exp[63:0]);
    end
  endtask

  task automatic chk_seed(input string tag, input logic [255:0] exp);
    chk({tag, "_lo"}, smp_seed[63:0], exp[63:0]);
    chk({tag, "_hi"}, smp_seed[255:192], exp[255:192]);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  function automatic logic [2047:0] mkpoly(input logic [7:0] base);
    logic [2047:0] p;
    for (int i = 0; i < 256; i++) p[8*i +: 8] = base + 8'(i);
    return p;
  endfunction

  // Called at the start of an IDLE cycle with the request inputs already set.
  task automatic run_job(input logic [N-1:0] exp_gnt, input logic [7:0] exp_n,
                         input logic [255:0] exp_seed, input logic exp_eta,
                         input int lat, input logic [2047:0] p);
    neg();
    chk("job_gnt", gnt, exp_gnt);
    chk("job_idle_busy", busy, 0);
    chk("job_idle_valid", rsp_valid, 0);
    cyc();
    neg();
    chk("job_run", run, 1);
    chk("job_N", smp_N, exp_n);
    chk_seed("job_seed", exp_seed);
    chk("job_eta", smp_eta, exp_eta);
    chk("job_gnt_off", gnt, 0);
    repeat (lat - 2) cyc();
    neg();
    chk("job_wait_run", run, 0);
    cyc();
    done = 1'b1;
    smp_poly = p;
    neg();
    chk("job_valid_early", rsp_valid, 0);
    cyc();
    done = 1'b0;
    smp_poly = ~p;
    neg();
    chk("job_valid", rsp_valid, exp_gnt);
    chk_poly("job_poly", p);
    rsp_ready = exp_gnt;
    cyc();
    rsp_ready = '0;
  endtask

  initial begin
    p1 = mkpoly(8'h10); p2 = mkpoly(8'h20); p3 = mkpoly(8'h30); p4 = mkpoly(8'h40);
    p5 = mkpoly(8'h50); p6 = mkpoly(8'h60); p7 = mkpoly(8'h70); p8 = mkpoly(8'h80);
    seed0_a = 256'h1;
    seed0_b = {64'hA0A0_0000_0000_0001, 128'h0, 64'h0000_0000_0000_00A0};
    seed1_b = {64'hB1B1_0000_0000_0002, 128'h0, 64'h0000_0000_0000_00B1};

    rst_n = 1'b0; req = 2'b11; req_seed = '0; req_N = '0; req_eta = '0;
    rsp_ready = '0; done = 1'b0; smp_poly = '0;
    cyc(); cyc();
    neg();
    chk("rst_gnt", gnt, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_run", run, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk_poly("rst_poly", '0);
    chk_seed("rst_seed", '0);
    chk("rst_N", smp_N, 0);
    chk("rst_eta", smp_eta, 0);
    rst_n = 1'b1;
    req = '0;
    cyc();

    // Single job, done 20 cycles after grant
    req = 2'b01; req_seed[255:0] = seed0_a; req_N[7:0] = 8'd3; req_eta[0] = 1'b0;
    run_job(2'b01, 8'd3, seed0_a, 1'b0, 20, p1);
    req = '0;

    // Reset while waiting on the sampler
    req = 2'b01; req_N[7:0] = 8'd7;
    neg();
    chk("mid_gnt", gnt, 2'b01);
    cyc();
    req = '0;
    cyc(); cyc();
    rst_n = 1'b0;
    cyc();
    neg();
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_run", run, 0);
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_N", smp_N, 0);
    chk_seed("mid_rst_seed", '0);
    chk_poly("mid_rst_poly", '0);
    rst_n = 1'b1;
    cyc();

    // Contention: pointer back at reset value, so order is 0,1,0
    req = 2'b11;
    req_seed = {seed1_b, seed0_b}; req_N = {8'd9, 8'd5}; req_eta = 2'b10;
    run_job(2'b01, 8'd5, seed0_b, 1'b0, 6, p2);
    run_job(2'b10, 8'd9, seed1_b, 1'b1, 4, p3);
    run_job(2'b01, 8'd5, seed0_b, 1'b0, 3, p4);

    // Backpressure with requester 1 waiting and a spurious done in RESP
    req = 2'b01;
    neg();
    chk("bp_gnt", gnt, 2'b01);
    cyc();
    req = 2'b11;
    cyc(); cyc();
    done = 1'b1; smp_poly = p5;
    cyc();
    for (int i = 0; i < 5; i++) begin
      done = (i == 2);
      smp_poly = p6;
      rsp_ready = (i == 3) ? 2'b10 : 2'b00;
      neg();
      chk("bp_valid", rsp_valid, 2'b01);
      chk_poly("bp_poly", p5);
      chk("bp_gnt_off", gnt, 0);
      chk("bp_run_off", run, 0);
      cyc();
    end
    done = 1'b0;
    rsp_ready = 2'b01;
    neg();
    chk("bp_hs_gnt", gnt, 0);
    chk("bp_hs_valid", rsp_valid, 2'b01);
    cyc();
    rsp_ready = '0;
    neg();
    chk("bp_next_gnt", gnt, 2'b10);
    cyc();
    req = '0;
    neg();
    chk("bp1_run", run, 1);
    chk("bp1_N", smp_N, 9);
    cyc();
    done = 1'b1; smp_poly = p7;
    cyc();
    done = 1'b0;
    neg();
    chk("bp1_valid", rsp_valid, 2'b10);
    chk_poly("bp1_poly", p7);
    rsp_ready = 2'b10;
    cyc();
    rsp_ready = '0;

    // Spurious done while idle
    done = 1'b1; smp_poly = p8;
    neg();
    chk("sp_busy", busy, 0);
    cyc();
    done = 1'b0;
    neg();
    chk_poly("sp_poly", p7);
    chk("sp_busy2", busy, 0);
    chk("sp_valid", rsp_valid, 0);
    cyc();

`ifdef CBD_ARB_TIMEOUT_EN
    // Watchdog: done withheld, err_o pulses 8 cycles into WAIT
    req = 2'b01;
    neg();
    chk("to_gnt", gnt, 2'b01);
    cyc();
    req = '0;
    for (int i = 2; i <= 9; i++) begin
      cyc();
      neg();
      chk("to_err_low", err, 0);
    end
    cyc();
    neg();
    chk("to_err", err, 1);
    chk("to_valid", rsp_valid, 0);
    chk("to_busy", busy, 0);
    cyc();
    req = 2'b01;
    neg();
    chk("to_err_off", err, 0);
    chk("to_regnt", gnt, 2'b01);
    cyc();
    req = '0;
`endif

    repeat (3) cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
